leaf_bft_packetizer: RTL

Transmit-side leaf block. Accepts up to NUM_OUT_PORTS user output streams (HLS ap_vld/ap_ack handshake) and arbitrates among them round-robin. Each accepted word becomes one PACKET_BITS packet toward the BFT. Per-port destination config, per-port address sequencing, per-port destination credits and a resend replay path are included.

---
 rtl/leaf_bft_packetizer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/leaf_bft_packetizer.sv
// Transmit leaf: round-robin arbiter over user streams, packetizes words toward the BFT.
// Define LEAF_BFT_PACKETIZER_STATS_EN to add pkt_count / stall_count outputs.
module leaf_bft_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_OUT_PORTS         = 4,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                    clk_bft,
  input  logic                                    reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
  output logic [PACKET_BITS-1:0]                  dout_leaf_interface2bft,
  input  logic                                    resend,
  input  logic                                    cfg_we,
  input  logic [NUM_PORT_BITS-1:0]                cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]                cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0]                cfg_dport,
  input  logic                                    credit_vld,
  input  logic [NUM_PORT_BITS-1:0]                credit_port,
  input  logic [$clog2(FREESPACE_UPDATE_SIZE):0]  credit_amt
`ifdef LEAF_BFT_PACKETIZER_STATS_EN
  ,
  output logic [31:0]                             pkt_count,
  output logic [31:0]                             stall_count
`endif
);

  localparam int CW = $clog2(FREESPACE_UPDATE_SIZE) + 1;
  localparam int SW = CW + 1;
  localparam int unsigned NP = NUM_OUT_PORTS;
  localparam logic [SW-1:0] CREDIT_MAX = SW'(FREESPACE_UPDATE_SIZE);

  logic [NUM_OUT_PORTS-1:0] cfg_valid_q, cfg_valid_d;
  logic [NUM_LEAF_BITS-1:0] cfg_leaf_q  [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0] cfg_leaf_d  [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] cfg_dport_q [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] cfg_dport_d [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_q      [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_d      [NUM_OUT_PORTS];
  logic [CW-1:0]            credit_q    [NUM_OUT_PORTS];
  logic [CW-1:0]            credit_d    [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] rr_q, rr_d;
  logic [PACKET_BITS-1:0]   dout_q, dout_d;
  logic [PACKET_BITS-1:0]   last_q, last_d;

  logic [NUM_OUT_PORTS-1:0] elig;
  logic                     grant_vld;
  int unsigned              grant_idx;
  int unsigned              idx;
  logic [PACKET_BITS-1:0]   pkt;
  logic [SW-1:0]            credit_sum;

  always_comb begin
    elig      = '0;
    grant_vld = 1'b0;
    grant_idx = 0;
    idx       = 0;
    pkt       = '0;
    for (int unsigned i = 0; i < NP; i++)
      elig[i] = vld_user2interface[i] & cfg_valid_q[i] & (credit_q[i] != '0) & ~resend;

    // Rotating search from the RR pointer; the first eligible port wins.
    for (int unsigned k = 0; k < NP; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= NP) idx = idx - NP;
      for (int unsigned i = 0; i < NP; i++)
        if (!grant_vld && i == idx && elig[i]) begin
          grant_vld = 1'b1;
          grant_idx = i;
        end
    end

    for (int unsigned i = 0; i < NP; i++) begin
      ack_interface2user[i] = grant_vld && grant_idx == i && !reset;
      if (grant_vld && grant_idx == i)
        pkt = {1'b1, cfg_leaf_q[i], cfg_dport_q[i], addr_q[i],
               din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
    end
  end

  always_comb begin
    dout_d      = resend ? last_q : (grant_vld ? pkt : '0);
    last_d      = grant_vld ? pkt : last_q;
    rr_d        = rr_q;
    cfg_valid_d = cfg_valid_q;
    credit_sum  = '0;
    if (grant_vld)
      rr_d = (grant_idx + 1 == NP) ? '0 : NUM_PORT_BITS'(grant_idx + 1);
    for (int unsigned i = 0; i < NP; i++) begin
      cfg_leaf_d[i]  = cfg_leaf_q[i];
      cfg_dport_d[i] = cfg_dport_q[i];
      addr_d[i]      = addr_q[i];
      if (cfg_we && cfg_port == NUM_PORT_BITS'(i)) begin
        cfg_valid_d[i] = 1'b1;
        cfg_leaf_d[i]  = cfg_leaf;
        cfg_dport_d[i] = cfg_dport;
      end
      if (grant_vld && grant_idx == i)
        addr_d[i] = addr_q[i] + 1'b1;
      // Return and consumption combine before saturation so a same-cycle pair nets correctly.
      credit_sum = SW'(credit_q[i])
                 + ((credit_vld && credit_port == NUM_PORT_BITS'(i)) ? SW'(credit_amt) : '0)
                 - ((grant_vld && grant_idx == i) ? SW'(1) : '0);
      if (credit_sum > CREDIT_MAX) credit_sum = CREDIT_MAX;
      credit_d[i] = CW'(credit_sum);
    end
  end

  always_ff @(posedge clk_bft) begin
    if (reset) begin
      cfg_valid_q <= '0;
      rr_q        <= '0;
      dout_q      <= '0;
      last_q      <= '0;
      for (int unsigned i = 0; i < NP; i++) begin
        cfg_leaf_q[i]  <= '0;
        cfg_dport_q[i] <= '0;
        addr_q[i]      <= '0;
        credit_q[i]    <= CW'(FREESPACE_UPDATE_SIZE);
      end
    end else begin
      cfg_valid_q <= cfg_valid_d;
      rr_q        <= rr_d;
      dout_q      <= dout_d;
      last_q      <= last_d;
      for (int unsigned i = 0; i < NP; i++) begin
        cfg_leaf_q[i]  <= cfg_leaf_d[i];
        cfg_dport_q[i] <= cfg_dport_d[i];
        addr_q[i]      <= addr_d[i];
        credit_q[i]    <= credit_d[i];
      end
    end
  end

  assign dout_leaf_interface2bft = dout_q;

`ifdef LEAF_BFT_PACKETIZER_STATS_EN
  logic [31:0] pkt_count_q, pkt_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    pkt_count_d   = pkt_count_q + (grant_vld ? 32'd1 : 32'd0);
    stall_count_d = stall_count_q +
                    ((|vld_user2interface && !grant_vld && !resend) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk_bft) begin
    if (reset) begin
      pkt_count_q   <= '0;
      stall_count_q <= '0;
    end else begin
      pkt_count_q   <= pkt_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign pkt_count   = pkt_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule
